bist_resp_analyzer: RTL

Output response analyzer for the BIST/ATPG path: compacts the circuit-under-test responses to the generated test patterns into a multiple-input signature register (MISR). After a programmed number of responses it compares the signature against a golden value and reports pass/fail. It sits on the response side of the CUT, opposite the pattern generator, and shares that generator's clock.

---
 rtl/bist_resp_analyzer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bist_resp_analyzer.sv
// -----------------------------------------------------------------------------
// bist_resp_analyzer
//
// Output response analyzer for the BIST/ATPG path. It compacts circuit-under-test
// responses into a multiple-input signature register (MISR). After PATTERN_COUNT
// accepted responses, it compares the signature with GOLDEN and reports pass/fail.
//
// Parameters:
//   WIDTH          response / signature width (>= 2)
//   PATTERN_COUNT  responses compacted per run (>= 1)
//   POLY           MISR feedback taps (bit i set: feedback XORs into bit i)
//   SEED           signature value loaded at reset and at every run start
//   GOLDEN         expected final signature
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   begin a run (sampled in IDLE or DONE only)
//   resp_valid  in   resp_in carries a CUT response this cycle
//   resp_in     in   CUT response word
//   resp_mask   in   (BSA_XMASK_EN only) bits forced to 0 before compaction
//   busy        out  high while in RUN
//   done        out  high while in DONE
//   pass        out  in DONE: signature == GOLDEN; 0 otherwise
//   signature   out  current MISR contents
//   count       out  responses accepted this run
//
// Optional feature macro: BSA_XMASK_EN (adds resp_mask X-masking).
//
// Handshake: no backpressure exists. A response is taken on every rising edge
// where resp_valid = 1 and the FSM is in RUN. At all other times, resp_valid is
// ignored.
// -----------------------------------------------------------------------------
module bist_resp_analyzer #(
    parameter int               WIDTH         = 5,
    parameter int               PATTERN_COUNT = 31,
    parameter logic [WIDTH-1:0] POLY          = 5'b00101,
    parameter logic [WIDTH-1:0] SEED          = '0,
    parameter logic [WIDTH-1:0] GOLDEN        = '0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   resp_valid,
    input  logic [WIDTH-1:0]                       resp_in,
`ifdef BSA_XMASK_EN
    input  logic [WIDTH-1:0]                       resp_mask,
`endif
    output logic                                   busy,
    output logic                                   done,
    output logic                                   pass,
    output logic [WIDTH-1:0]                       signature,
    output logic [$clog2(PATTERN_COUNT+1)-1:0]     count
);

    localparam int            CW   = $clog2(PATTERN_COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(PATTERN_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] misr_next;

    // This is the word that gets compacted. Masked bits are unknown X-sources, so
    // they are forced to 0 and cannot corrupt the signature.
`ifdef BSA_XMASK_EN
    assign word = resp_in & ~resp_mask;
`else
    assign word = resp_in;
`endif

    // MISR step: shift left. If the MSB falls out, fold it back through POLY.
    // Then XOR in the response word.
    assign misr_next = {sig_q[WIDTH-2:0], 1'b0}
                     ^ (sig_q[WIDTH-1] ? POLY : '0)
                     ^ word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE, DONE: begin
                // Every run starts from a clean slate, including a restart out of DONE.
                if (start) begin
                    state_d = RUN;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (resp_valid) begin
                    sig_d = misr_next;
                    cnt_d = cnt_q + CW'(1);
                    // The verdict is taken from the next-state signature. This makes
                    // pass valid in the first DONE cycle.
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        pass_d  = (misr_next == GOLDEN);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign signature = sig_q;
    assign count     = cnt_q;

endmodule
